// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC register, inst_cache handshake and a
// 2-entry {pc, instruction} buffer feeding decode, with redirect and miss tracking.
module inst_fetch #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter logic [WORD_SIZE-1:0] PC_STEP   = WORD_SIZE'(1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] ic_addr,
  input  logic [WORD_SIZE-1:0] ic_data,
  input  logic                 ic_hit,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 inst_ready,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] inst_out,
  output logic [WORD_SIZE-1:0] inst_pc,
  output logic [31:0]          miss_cycles
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_MISS  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]           state_q, state_nxt;
  logic [WORD_SIZE-1:0] pc_q, pc_nxt;
  logic                 push_c;
  logic                 pop_c;
  logic                 can_accept_c;

  logic [WORD_SIZE-1:0] buf_pc   [DEPTH];
  logic [WORD_SIZE-1:0] buf_data [DEPTH];
  logic                 rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count;

  assign pop_c        = (count != '0) && inst_ready;
  assign can_accept_c = (count < CNT_W'(DEPTH)) || pop_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state, push decision and next PC; redirect overrides everything
  always_comb begin
    state_nxt = state_q;
    push_c    = 1'b0;
    pc_nxt    = pc_q;
    case (state_q)
      ST_FETCH, ST_MISS: begin
        if (ic_hit) begin
          if (can_accept_c) begin
            push_c    = 1'b1;
            pc_nxt    = pc_q + PC_STEP;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_FULL;
          end
        end else begin
          state_nxt = ST_MISS;
        end
      end
      ST_FULL: begin
        if (pop_c) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
    if (redirect) begin
      state_nxt = ST_FETCH;
      push_c    = 1'b0;
      pc_nxt    = redirect_pc;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_nxt;
    end
  end

  // Two-entry buffer; redirect flushes and drops any same-cycle pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
    end else if (redirect) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_c) begin
        buf_pc[wr_ptr]   <= pc_q;
        buf_data[wr_ptr] <= ic_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_c) rd_ptr <= ~rd_ptr;
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating count of cycles spent waiting on the cache
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cycles <= '0;
    end else if ((state_q == ST_MISS) && (miss_cycles != '1)) begin
      miss_cycles <= miss_cycles + 32'd1;
    end
  end

  assign ic_addr    = pc_q;
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? buf_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, miss, backpressure, async reset,
// redirect and PC wrap, with the cache returning addr+0x100 on every hit.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] ic_addr;
  logic [31:0] ic_data;
  logic        ic_hit;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] miss_cycles;

  int total = 0;
  int bad   = 0;

  inst_fetch #(.WORD_SIZE(32), .RESET_PC(32'h0), .PC_STEP(32'h1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ic_addr     (ic_addr),
    .ic_data     (ic_data),
    .ic_hit      (ic_hit),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_ready  (inst_ready),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .miss_cycles (miss_cycles)
  );

  assign ic_data = ic_addr + 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    ic_hit      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    @(negedge clk);
    chk("rst_addr",  ic_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_out",   inst_out, 32'h0);
    chk("rst_pc",    inst_pc, 32'h0);
    chk("rst_miss",  miss_cycles, 32'h0);

    // Streaming: one instruction per cycle, pc 0..4
    rst_n      = 1'b1;
    ic_hit     = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stream_valid", 32'(inst_valid), 32'h1);
      chk("stream_pc",    inst_pc, 32'(i));
      chk("stream_out",   inst_out, 32'h100 + 32'(i));
    end
    chk("stream_addr", ic_addr, 32'h5);
    chk("stream_miss", miss_cycles, 32'h0);

    // Miss for three cycles at address 5
    ic_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("miss_addr",  ic_addr, 32'h5);
      chk("miss_valid", 32'(inst_valid), 32'h0);
    end
    ic_hit = 1'b1;
    step();
    chk("miss_cnt",    miss_cycles, 32'h3);
    chk("miss_pc",     inst_pc, 32'h5);
    chk("miss_out",    inst_out, 32'h105);
    chk("miss_next",   ic_addr, 32'h6);
    step();
    chk("miss_nodup",  inst_pc, 32'h6);

    // Enter MISS with one buffered entry, then async reset mid-cycle
    inst_ready = 1'b0;
    ic_hit     = 1'b0;
    step();
    step();
    chk("pre_rst_valid", 32'(inst_valid), 32'h1);
    chk("pre_rst_pc",    inst_pc, 32'h6);
    chk("pre_rst_miss",  miss_cycles, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'h0);
    chk("arst_addr",  ic_addr, 32'h0);
    chk("arst_miss",  miss_cycles, 32'h0);
    chk("arst_pc",    inst_pc, 32'h0);
    @(negedge clk);

    // Backpressure: two entries buffered, FULL holds address 2
    rst_n  = 1'b1;
    ic_hit = 1'b1;
    step();
    step();
    step();
    chk("full_addr",  ic_addr, 32'h2);
    chk("full_pc",    inst_pc, 32'h0);
    step();
    chk("full_hold",  ic_addr, 32'h2);
    chk("full_valid", 32'(inst_valid), 32'h1);
    inst_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_pc",  inst_pc, 32'(i));
      chk("drain_out", inst_out, 32'h100 + 32'(i));
    end
    chk("drain_addr", ic_addr, 32'h4);

    // Redirect with two entries buffered and a hit in the same cycle
    inst_ready = 1'b0;
    step();
    chk("pre_redir_pc", inst_pc, 32'h3);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("redir_valid", 32'(inst_valid), 32'h0);
    chk("redir_addr",  ic_addr, 32'h40);
    inst_ready = 1'b1;
    step();
    chk("redir_pc",  inst_pc, 32'h40);
    chk("redir_out", inst_out, 32'h140);

    // PC wraps from all-ones to zero
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("wrap_addr0", ic_addr, 32'hFFFF_FFFF);
    step();
    chk("wrap_pc0",   inst_pc, 32'hFFFF_FFFF);
    chk("wrap_out0",  inst_out, 32'h0000_00FF);
    chk("wrap_addr1", ic_addr, 32'h0);
    step();
    chk("wrap_pc1",   inst_pc, 32'h0);
    chk("wrap_out1",  inst_out, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
